// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch slice.
//   - fetch_state_e : 2-bit controller state (BOOT, RUN, HALT)
//   - DATA_W_DEF    : default instruction / pc width
//   - ADDR_W_DEF    : default ROM address width
//   - RESET_VEC_DEF : default address loaded into the pc after reset
package fetch_pkg;

  localparam int          DATA_W_DEF    = 16;
  localparam int          ADDR_W_DEF    = 15;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry synchronous FIFO holding fetched {pc, instr} words.
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-low reset
//   push/push_data - write one entry (accepted when not full, or full with a pop)
//   pop            - retire the head entry (ignored when empty)
//   flush          - discard all entries; applied after this cycle's pop/push
//   head_data      - current head entry (registered storage)
//   count          - number of valid entries
//   valid          - head entry is valid
import fetch_pkg::*;

module fetch_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (cnt_q != '0);
    // A full buffer can still take a word when the head leaves the same cycle.
    do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign valid     = (cnt_q != '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch controller sitting downstream of the pc block.
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-low reset
//   pc_out                - current pc value
//   pc_in/pc_load/pc_inc  - pc control (load target / load strobe / increment)
//   rom_en/rom_addr       - synchronous ROM read request
//   rom_data              - ROM read data, valid the cycle after rom_en
//   jmp_valid/jmp_addr    - single-cycle redirect request and target
//   halt                  - level request to stop issuing new fetches
//   instr_valid/ready     - handshake toward decode
//   instr_data/instr_pc   - head instruction and its address
import fetch_pkg::*;

module fetch_unit #(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_in,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jmp_valid,
  input  logic [DATA_W-1:0] jmp_addr,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [DATA_W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
  logic              discard_q, discard_d;

  logic [CW-1:0]       buf_count;
  logic [2*DATA_W-1:0] buf_head;
  logic                pop, push, flush, issue, credit_ok;
  logic [CW:0]         used;

  assign pop  = instr_valid & instr_ready;
  assign push = pending_q & ~discard_q;

  // Slots committed after this edge: buffered words, plus the word still
  // returning from the ROM, minus the head leaving now. Issuing only while
  // this is below DEPTH keeps the buffer from ever overflowing.
  assign used      = {1'b0, buf_count} + {{CW{1'b0}}, pending_q} - {{CW{1'b0}}, pop};
  assign credit_ok = (used < (CW+1)'(DEPTH));

  always_comb begin
    state_d   = state_q;
    pending_d = 1'b0;
    pend_pc_d = pend_pc_q;
    discard_d = 1'b0;
    issue     = 1'b0;
    flush     = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_in     = '0;
    rom_en    = 1'b0;
    rom_addr  = '0;

    case (state_q)
      BOOT: begin
        pc_load = 1'b1;
        pc_in   = RESET_VEC;
        state_d = halt ? HALT : RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (credit_ok) begin
          issue = 1'b1;
        end
      end
      HALT: begin
        if (!halt) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    // A redirect overrides everything, including the BOOT load. The word
    // returning this cycle dies with the flush; discard marks it dead as well.
    if (jmp_valid) begin
      issue     = 1'b0;
      flush     = 1'b1;
      pc_load   = 1'b1;
      pc_in     = jmp_addr;
      discard_d = pending_q;
      state_d   = halt ? HALT : RUN;
    end

    if (issue) begin
      rom_en    = 1'b1;
      rom_addr  = pc_out[ADDR_W-1:0];
      pc_inc    = 1'b1;
      pending_d = 1'b1;
      pend_pc_d = pc_out;
    end

    // pc and ROM controls must fall as soon as reset is asserted, not at the
    // next edge.
    if (!rst) begin
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_in    = '0;
      rom_en   = 1'b0;
      rom_addr = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      pending_q <= 1'b0;
      pend_pc_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_buf #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pend_pc_q, rom_data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (buf_head),
    .count     (buf_count),
    .valid     (instr_valid)
  );

  assign instr_pc   = buf_head[2*DATA_W-1:DATA_W];
  assign instr_data = buf_head[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a pc block and a
// synchronous ROM (ROM[a] = 16'hA000 + a) modelled beside it.
module tb_fetch_unit;

  localparam logic [15:0] RESET_VEC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        pc_load, pc_inc, rom_en;
  logic [14:0] rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        jmp_valid = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic        halt = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data, instr_pc;

  int checks = 0;
  int errors = 0;

  // Expected-stream model state
  logic [15:0] exp_pc = 16'h0000;
  int          delivered = 0;
  int          issues = 0;
  logic [15:0] last_pc = 16'h0000;
  logic [15:0] last_data = 16'h0000;
  logic        prev_stall = 1'b0;
  logic        prev_jmp = 1'b0;
  logic [15:0] prev_pc = 16'h0000;
  logic [15:0] prev_data = 16'h0000;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_out      (pc_out),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc)
  );

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return 16'hA000 + {1'b0, a};
  endfunction

  // pc block beside the fetch unit; its own reset value differs from
  // RESET_VEC so the BOOT load is observable.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_out <= 16'h1234;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc) pc_out <= pc_out + 16'h0001;
  end

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic hlt, input logic jv,
                               input logic [15:0] ja, input int cycles);
    instr_ready = rdy;
    halt        = hlt;
    jmp_valid   = jv;
    jmp_addr    = ja;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: words leave in fetch order starting at RESET_VEC; a jump restarts
  // the stream at its target after any pop in the same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_pc     = RESET_VEC;
      prev_stall = 1'b0;
      prev_jmp   = 1'b0;
    end else begin
      checkOutput("load_inc_excl", {31'd0, pc_load & pc_inc}, 32'd0);
      checkOutput("inc_with_en", {31'd0, pc_inc}, {31'd0, rom_en});
      if (halt || jmp_valid) checkOutput("no_issue", {31'd0, rom_en}, 32'd0);
      if (rom_en) checkOutput("rom_addr", {17'd0, rom_addr}, {17'd0, pc_out[14:0]});
      if (jmp_valid) begin
        checkOutput("jmp_load", {31'd0, pc_load}, 32'd1);
        checkOutput("jmp_pc_in", {16'd0, pc_in}, {16'd0, jmp_addr});
      end
      if (prev_stall && !prev_jmp) begin
        checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("hold_pc", {16'd0, instr_pc}, {16'd0, prev_pc});
        checkOutput("hold_data", {16'd0, instr_data}, {16'd0, prev_data});
      end
      if (rom_en) issues++;
      if (instr_valid && instr_ready) begin
        checkOutput("seq_pc", {16'd0, instr_pc}, {16'd0, exp_pc});
        checkOutput("seq_data", {16'd0, instr_data}, {16'd0, rom_word(exp_pc[14:0])});
        last_pc   = instr_pc;
        last_data = instr_data;
        exp_pc    = exp_pc + 16'h0001;
        delivered++;
      end
      if (jmp_valid) exp_pc = jmp_addr;
      prev_stall = instr_valid && !instr_ready;
      prev_jmp   = jmp_valid;
      prev_pc    = instr_pc;
      prev_data  = instr_data;
    end
  end

  // Called at posedge+1 right after reset release with ready high.
  task automatic bootCheck();
    @(negedge clk);
    checkOutput("boot_pc_load", {31'd0, pc_load}, 32'd1);
    checkOutput("boot_pc_in", {16'd0, pc_in}, {16'd0, RESET_VEC});
    checkOutput("boot_rom_en", {31'd0, rom_en}, 32'd0);
    @(negedge clk);
    checkOutput("c1_rom_en", {31'd0, rom_en}, 32'd1);
    checkOutput("c1_rom_addr", {17'd0, rom_addr}, 32'd0);
    checkOutput("c1_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    checkOutput("c2_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("boot_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("boot_pc", {16'd0, instr_pc}, 32'(i));
      checkOutput("boot_data", {16'd0, instr_data}, 32'h0000A000 + 32'(i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDeliver(output logic [15:0] pc, output logic [15:0] data);
    int n0 = delivered;
    int k = 0;
    while (delivered == n0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("deliver_timeout", {31'd0, delivered != n0}, 32'd1);
    pc   = last_pc;
    data = last_data;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n0, i0;
    logic [15:0] p, d;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_pc_load", {31'd0, pc_load}, 32'd0);
    checkOutput("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    checkOutput("rst_pc_in", {16'd0, pc_in}, 32'd0);
    checkOutput("rst_rom_en", {31'd0, rom_en}, 32'd0);
    checkOutput("rst_rom_addr", {17'd0, rom_addr}, 32'd0);

    rst = 1'b1;
    bootCheck();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 3);

    // Decode stalls for 5 cycles, then resumes
    n0 = delivered; i0 = issues;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 5);
    checkOutput("stall_deliver", 32'(delivered - n0), 32'd0);
    checkOutput("stall_issue", 32'(issues - i0), 32'd0);
    n0 = delivered;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4);
    checkOutput("release_deliver", 32'(delivered - n0), 32'd4);

    // Halt for 4 cycles: the buffered and pending words still drain
    n0 = delivered; i0 = issues;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 4);
    checkOutput("halt_deliver", 32'(delivered - n0), 32'd2);
    checkOutput("halt_issue", 32'(issues - i0), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 6);

    // Jump with a read pending and decode stalled
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 0);
    waitDeliver(p, d);
    checkOutput("jmp40_pc", {16'd0, p}, 32'h0040);
    checkOutput("jmp40_data", {16'd0, d}, 32'hA040);

    // Jump with the buffer full
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0080, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 0);
    waitDeliver(p, d);
    checkOutput("jmp80_pc", {16'd0, p}, 32'h0080);
    checkOutput("jmp80_data", {16'd0, d}, 32'hA080);

    // Jump in the same cycle as a pop
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0100, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 0);
    waitDeliver(p, d);
    checkOutput("jmp100_pc", {16'd0, p}, 32'h0100);
    checkOutput("jmp100_data", {16'd0, d}, 32'hA100);

    // Address wrap at the top of the 16-bit pc space
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFE, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 0);
    waitDeliver(p, d);
    checkOutput("wrap0_pc", {16'd0, p}, 32'hFFFE);
    checkOutput("wrap0_data", {16'd0, d}, 32'h1FFE);
    waitDeliver(p, d);
    checkOutput("wrap1_pc", {16'd0, p}, 32'hFFFF);
    checkOutput("wrap1_data", {16'd0, d}, 32'h1FFF);
    waitDeliver(p, d);
    checkOutput("wrap2_pc", {16'd0, p}, 32'h0000);
    checkOutput("wrap2_data", {16'd0, d}, 32'hA000);

    // Reset mid-stream with a read pending
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("arst_rom_en", {31'd0, rom_en}, 32'd0);
    checkOutput("arst_pc_inc", {31'd0, pc_inc}, 32'd0);
    checkOutput("arst_pc_load", {31'd0, pc_load}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bootCheck();

    // Jump during BOOT overrides the reset vector
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 0);
    waitDeliver(p, d);
    checkOutput("bootjmp_pc", {16'd0, p}, 32'h0020);
    checkOutput("bootjmp_data", {16'd0, d}, 32'hA020);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch controller that sits directly downstream of the program counter.
- Consumes the pc output and drives the pc's in/load/inc controls.
- Issues synchronous reads to the instruction ROM and buffers returned words in a small FIFO.
- Presents {instruction, address} to decode over a valid/ready handshake; handles jump redirects and halt.

Parameters:
- DATA_W, 16, instruction and pc width.
- ADDR_W, 15, ROM address width; rom_addr is pc_out[ADDR_W-1:0].
- DEPTH, 2, instruction buffer entries (power of 2, >=2).
- RESET_VEC, 16'h0000, address loaded into pc after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_out  in  DATA_W  current pc value from pc block.
- pc_in  out  DATA_W  load value to pc.
- pc_load  out  1  pc load strobe.
- pc_inc  out  1  pc increment strobe.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data, valid the cycle after rom_en.
- jmp_valid  in  1  redirect request, single-cycle pulse.
- jmp_addr  in  DATA_W  redirect target.
- halt  in  1  suspend new fetches (level).
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  decode accepts head.
- instr_data  out  DATA_W  head instruction.
- instr_pc  out  DATA_W  address of head instruction.

Behaviour:
- Reset (rst=0, async):
  - state=BOOT; buffer empty; pending=0; discard=0.
  - All outputs 0: instr_valid, pc_load, pc_inc, pc_in, rom_en, rom_addr.
- FSM states:
  - BOOT: one cycle; pc_load=1, pc_in=RESET_VEC, no issue. Next state RUN, or HALT if halt=1.
  - RUN: fetch issue allowed.
  - HALT: no issue. Return to RUN the cycle after halt drops. The buffer keeps draining while halted.
- Issue rule:
  - Condition: state==RUN && !jmp_valid && (count + pending - pop) < DEPTH, where pop = instr_valid & instr_ready.
  - On issue in the same cycle: rom_en=1, rom_addr=pc_out[ADDR_W-1:0], pc_inc=1. Register pending=1 and pend_pc=pc_out.
- Return path:
  - The cycle after issue, rom_data is written into the buffer with tag pend_pc.
  - If discard=1, the word is dropped instead.
  - Push and pop can occur in the same cycle.
- Latency and throughput:
  - ROM to instr_valid: 1 cycle after the data cycle; buffer head is registered.
  - Sustained throughput: 1 instr/cycle when instr_ready stays high.
  - Credit accounting guarantees the buffer never overflows.
- Jump (jmp_valid=1), highest priority, any state including BOOT and HALT:
  - pc_load=1, pc_in=jmp_addr, pc_inc=0, no issue.
  - Flush the buffer (count=0) in the same edge.
  - If pending, set discard=1 so the in-flight word is dropped.
  - A pop in the jump cycle completes normally before the flush.
  - The next RUN cycle issues at jmp_addr.
  - A jump in BOOT overrides RESET_VEC.
  - State after a jump: RUN, or HALT if halt=1.
- Halt priority: below jump, above issue.
  - Halt asserted while a read is pending: the pending word is still captured (not discarded).
- Output ordering and stability:
  - instr_data and instr_pc are stable while instr_valid=1 && instr_ready=0.
  - Words leave in fetch order.
  - instr_pc of consecutive sequential words increments by 1 (16-bit wrap: 16'hFFFF -> 16'h0000; rom_addr wraps accordingly).
- pc_load and pc_inc are never both 1.
- Reset mid-operation: immediate clear to the reset values above; any ROM data returning after reset is ignored.

Decomposition:
- fetch_pkg:
  - State encodings BOOT/RUN/HALT (2-bit).
  - DATA_W/ADDR_W defaults and RESET_VEC default.
- Sub-module fetch_buf:
  - DEPTH-entry synchronous FIFO of {pc, instr}, DATA_W*2 wide.
  - push/pop/flush/count and async active-low reset.
  - Instantiated once.
- The ROM remains the existing external memory block; the pc block is instantiated beside fetch_unit, not inside it.

Test Plan:
- Reset release with RESET_VEC=16'h0000, ROM[i]=16'hA000+i, instr_ready=1 -> BOOT pulses pc_load with pc_in=0; instr_valid first high 3 cycles after BOOT; words 16'hA000, A001, A002 delivered back-to-back with instr_pc 0,1,2.
- instr_ready=0 for 5 cycles during streaming -> at most DEPTH=2 words buffered; issue stops; head held stable; after release the sequence continues with no gap or duplicate.
- jmp_valid with jmp_addr=16'h0040 while a read is pending and the buffer holds 2 words -> buffer flushed; pending word dropped; next delivered word is ROM[0x40] with instr_pc=16'h0040.
- halt=1 for 4 cycles mid-stream -> rom_en=0 and pc_inc=0 throughout; already-buffered and pending words still delivered; fetch resumes at the next sequential address.
- Jump in the same cycle as a pop -> the popped word is accepted once; no stale word appears afterwards.
- rst driven low mid-stream with pending=1 -> instr_valid, rom_en, pc_inc, pc_load drop asynchronously; after release the BOOT sequence repeats from RESET_VEC.
